// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and constants for the SHA-256 message padder.
// Imported by the padder top and its byte-padding helper.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WORDS   = 16;
  localparam int LEN_W   = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_LAT,
    S_WAITC,
    S_EXTRA,
    S_DONE
  } state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: masks unused bytes of a final message word and drops
// the 0x80 pad byte into the first free byte position.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  input  logic              last,
  output logic [WORD_W-1:0] word,
  output logic              spill
);

  // 0x80 belongs to the next word when all four bytes are message data
  assign spill = last && (nbytes == 3'd4);

  // keep bytes below nbytes, pad byte at nbytes, zeros above
  always_comb begin
    word = data;
    if (last) begin
      for (int i = 0; i < 4; i++) begin
        if (i == int'(nbytes))
          word[31-8*i -: 8] = PAD_BYTE;
        else if (i > int'(nbytes))
          word[31-8*i -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: packs a 32-bit word stream into padded 512-bit blocks
// and sequences init/next pulses into the SHA-256 core.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int BYTE_CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [2:0]         s_nbytes,
  input  logic               cont_i,
  input  logic [63:0]        len_offset_i,
  output logic               sha_init_o,
  output logic               sha_next_o,
  output logic [BLOCK_W-1:0] sha_block_o,
  input  logic               sha_ready_i,
  input  logic               sha_digest_valid_i,
  output logic               done_o,
  output logic               busy_o
);

  state_t state, state_d;

  logic [0:WORDS-1][WORD_W-1:0] blk_w;
  logic [3:0]                   w;
  logic [BYTE_CNT_W-1:0]        byte_cnt;
  logic                         first;
  logic                         cont;
  logic                         final_f;
  logic                         pend_extra;
  logic                         pend_80;
  logic [LEN_W-1:0]             len_off;

  logic                  accept;
  logic                  pulse;
  logic [2:0]            nb;
  logic [WORD_W-1:0]     pw;
  logic                  spill;
  logic [BYTE_CNT_W-1:0] cnt_nxt;
  logic [6:0]            blk_bytes;
  logic                  fits;
  logic [LEN_W-1:0]      cur_off;
  logic [LEN_W-1:0]      len_fill;
  logic [LEN_W-1:0]      len_extra;
  logic                  unused_digest;

  assign unused_digest = sha_digest_valid_i;

  assign sha_block_o = blk_w;
  assign accept      = s_valid && s_ready;
  assign pulse       = (state == S_ISSUE) && sha_ready_i;

  assign nb = !s_last             ? 3'd4 :
              (s_nbytes > 3'd4)   ? 3'd4 : s_nbytes;

  assign cnt_nxt   = byte_cnt + BYTE_CNT_W'(nb);
  assign blk_bytes = {1'b0, w, 2'b00} + 7'(nb);
  assign fits      = blk_bytes <= 7'd55;
  assign cur_off   = (state == S_IDLE) ? len_offset_i : len_off;
  assign len_fill  = (LEN_W'(cnt_nxt) << 3) + cur_off;
  assign len_extra = (LEN_W'(byte_cnt) << 3) + len_off;

  sha256_pad_word u_pad (
    .data   (s_data),
    .nbytes (nb),
    .last   (s_last),
    .word   (pw),
    .spill  (spill)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // next state and handshake/pulse outputs
  always_comb begin
    state_d    = state;
    s_ready    = 1'b0;
    sha_init_o = 1'b0;
    sha_next_o = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b0;
    unique case (state)
      S_IDLE, S_FILL: begin
        s_ready = !rst;
        busy_o  = (state == S_FILL);
        if (accept) begin
          if (s_last || w == 4'd15) state_d = S_ISSUE;
          else                      state_d = S_FILL;
        end
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (sha_ready_i) begin
          sha_init_o = first && !cont;
          sha_next_o = !(first && !cont);
          state_d    = S_LAT;
        end
      end
      S_LAT: begin
        busy_o  = 1'b1;
        state_d = S_WAITC;
      end
      S_WAITC: begin
        busy_o = 1'b1;
        if (sha_ready_i) begin
          if (final_f)         state_d = S_DONE;
          else if (pend_extra) state_d = S_EXTRA;
          else                 state_d = S_FILL;
        end
      end
      S_EXTRA: begin
        busy_o  = 1'b1;
        state_d = S_ISSUE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // block buffer, counters and per-message flags
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_w      <= '0;
      w          <= '0;
      byte_cnt   <= '0;
      first      <= 1'b1;
      cont       <= 1'b0;
      final_f    <= 1'b0;
      pend_extra <= 1'b0;
      pend_80    <= 1'b0;
      len_off    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_FILL: begin
          if (accept) begin
            if (state == S_IDLE) begin
              cont    <= cont_i;
              len_off <= len_offset_i;
            end
            blk_w[w] <= pw;
            byte_cnt <= cnt_nxt;
            w        <= w + 4'd1;
            final_f  <= 1'b0;
            if (s_last) begin
              if (spill && w != 4'd15)
                blk_w[w + 4'd1] <= {PAD_BYTE, 24'h0};
              if (fits) begin
                blk_w[14] <= len_fill[63:32];
                blk_w[15] <= len_fill[31:0];
                final_f   <= 1'b1;
              end else begin
                pend_extra <= 1'b1;
                pend_80    <= spill && (w == 4'd15);
              end
            end
          end
        end
        S_ISSUE: begin
          if (sha_ready_i) first <= 1'b0;
        end
        S_WAITC: begin
          if (sha_ready_i && !final_f && !pend_extra) begin
            blk_w <= '0;
            w     <= '0;
          end
        end
        S_EXTRA: begin
          blk_w      <= '0;
          blk_w[0]   <= pend_80 ? {PAD_BYTE, 24'h0} : 32'h0;
          blk_w[14]  <= len_extra[63:32];
          blk_w[15]  <= len_extra[31:0];
          final_f    <= 1'b1;
          pend_extra <= 1'b0;
          pend_80    <= 1'b0;
        end
        S_DONE: begin
          blk_w    <= '0;
          w        <= '0;
          byte_cnt <= '0;
          first    <= 1'b1;
          cont     <= 1'b0;
          final_f  <= 1'b0;
          len_off  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: scoreboard bench for the SHA-256 message padder.
// Expected blocks are queued at stimulus time and checked by a monitor.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic         s_last;
  logic [2:0]   s_nbytes;
  logic         cont_i;
  logic [63:0]  len_offset_i;
  logic         sha_init_o;
  logic         sha_next_o;
  logic [511:0] sha_block_o;
  logic         sha_ready_i;
  logic         sha_digest_valid_i;
  logic         done_o;
  logic         busy_o;

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk                (clk),
    .rst                (rst),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_last             (s_last),
    .s_nbytes           (s_nbytes),
    .cont_i             (cont_i),
    .len_offset_i       (len_offset_i),
    .sha_init_o         (sha_init_o),
    .sha_next_o         (sha_next_o),
    .sha_block_o        (sha_block_o),
    .sha_ready_i        (sha_ready_i),
    .sha_digest_valid_i (sha_digest_valid_i),
    .done_o             (done_o),
    .busy_o             (busy_o)
  );

  typedef struct {
    bit           is_done;
    bit           init;
    logic [511:0] blk;
    string        name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   passed   = 0;
  int   done_cnt = 0;
  bit   hold     = 1'b0;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  function automatic logic [31:0] mw(int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  function automatic logic [511:0] put(logic [511:0] b, int i,
                                       logic [31:0] v);
    b[511-32*i -: 32] = v;
    return b;
  endfunction

  task automatic exp_blk(string nm, bit init, logic [511:0] b);
    exp_t e;
    e.is_done = 1'b0;
    e.init    = init;
    e.blk     = b;
    e.name    = nm;
    q.push_back(e);
  endtask

  task automatic exp_done(string nm);
    exp_t e;
    e.is_done = 1'b1;
    e.init    = 1'b0;
    e.blk     = '0;
    e.name    = nm;
    q.push_back(e);
  endtask

  // core model: busy for a few cycles after each pulse
  initial begin
    int cnt;
    cnt = 0;
    sha_ready_i        = 1'b1;
    sha_digest_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      if (sha_init_o || sha_next_o) cnt = 6;
      @(posedge clk);
      #2;
      if (cnt > 0) cnt--;
      sha_ready_i        = (cnt == 0) && !hold;
      sha_digest_valid_i = (cnt == 0);
    end
  end

  // monitor: compare every pulse and done against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sha_init_o || sha_next_o) begin
        chk("pulse_excl", 512'(sha_init_o && sha_next_o), 512'(0));
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got pulse want none");
        end else begin
          e = q.pop_front();
          chk({e.name, "_kind"}, 512'(e.is_done), 512'(0));
          chk({e.name, "_init"}, 512'(sha_init_o), 512'(e.init));
          chk({e.name, "_blk"}, sha_block_o, e.blk);
        end
      end
      if (done_o) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done want none");
        end else begin
          e = q.pop_front();
          chk({e.name, "_done"}, 512'(e.is_done), 512'(1));
        end
      end
    end
  end

  task automatic send(logic [31:0] d, bit last, logic [2:0] nb);
    bit acc;
    int n;
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    s_nbytes = nb;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: got s_ready 0 want 1");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_pat(int nbytes);
    int nw;
    nw = (nbytes + 3) / 4;
    if (nw == 0) nw = 1;
    for (int i = 0; i < nw; i++) begin
      if (i == nw - 1) send(mw(i), 1'b1, 3'(nbytes - 4*i));
      else             send(mw(i), 1'b0, 3'd4);
    end
  endtask

  task automatic wait_done(int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (done_cnt >= target) passed++;
    else $display("FAIL done_timeout: got %0d want %0d", done_cnt, target);
  endtask

  initial begin
    logic [511:0] b;
    logic [511:0] b2;
    logic [511:0] held;
    logic [31:0]  t;
    bit           bad_p, bad_r, bad_b;

    rst          = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    s_last       = 1'b0;
    s_nbytes     = '0;
    cont_i       = 1'b0;
    len_offset_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 512'(s_ready), 512'(0));
    chk("rst_init", 512'(sha_init_o), 512'(0));
    chk("rst_next", 512'(sha_next_o), 512'(0));
    chk("rst_done", 512'(done_o), 512'(0));
    chk("rst_busy", 512'(busy_o), 512'(0));
    chk("rst_block", sha_block_o, 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 512'(s_ready), 512'(1));
    @(posedge clk);
    #1;

    b = put(put('0, 0, 32'h61626380), 15, 32'h18);
    exp_blk("abc", 1'b1, b);
    exp_done("abc");
    send(32'h616263FF, 1'b1, 3'd3);
    @(negedge clk);
    chk("abc_busy", 512'(busy_o), 512'(1));
    wait_done(1);

    b = put('0, 0, 32'h80000000);
    exp_blk("empty", 1'b1, b);
    exp_done("empty");
    send(32'hDEADBEEF, 1'b1, 3'd0);
    wait_done(2);

    b = '0;
    for (int i = 0; i < 13; i++) b = put(b, i, mw(i));
    t = mw(13);
    t[7:0] = 8'h80;
    b = put(put(b, 13, t), 15, 32'h1B8);
    exp_blk("m55", 1'b1, b);
    exp_done("m55");
    send_pat(55);
    wait_done(3);

    b = '0;
    for (int i = 0; i < 14; i++) b = put(b, i, mw(i));
    b = put(b, 14, 32'h80000000);
    b2 = put('0, 15, 32'h1C0);
    exp_blk("m56_b1", 1'b1, b);
    exp_blk("m56_b2", 1'b0, b2);
    exp_done("m56");
    send_pat(56);
    wait_done(4);

    b = '0;
    for (int i = 0; i < 16; i++) b = put(b, i, mw(i));
    b2 = put(put('0, 0, 32'h80000000), 15, 32'h200);
    exp_blk("m64_b1", 1'b1, b);
    exp_blk("m64_b2", 1'b0, b2);
    exp_done("m64");
    send_pat(64);
    wait_done(5);

    cont_i       = 1'b1;
    len_offset_i = 64'd512;
    b = put(put('0, 0, 32'h61626380), 15, 32'h218);
    exp_blk("cont", 1'b0, b);
    exp_done("cont");
    send(32'h61626300, 1'b1, 3'd3);
    cont_i       = 1'b0;
    len_offset_i = '0;
    wait_done(6);

    hold = 1'b1;
    b = put(put(put('0, 0, 32'h61626364), 1, 32'h80000000), 15, 32'h20);
    exp_blk("hold", 1'b1, b);
    exp_done("hold");
    send(32'h61626364, 1'b1, 3'd7);
    held  = sha_block_o;
    bad_p = 1'b0;
    bad_r = 1'b0;
    bad_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sha_init_o || sha_next_o) bad_p = 1'b1;
      if (s_ready) bad_r = 1'b1;
      if (sha_block_o !== held) bad_b = 1'b1;
    end
    chk("hold_no_pulse", 512'(bad_p), 512'(0));
    chk("hold_s_ready", 512'(bad_r), 512'(0));
    chk("hold_stable", 512'(bad_b), 512'(0));
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_pulse", 512'(sha_init_o), 512'(1));
    wait_done(7);

    send(mw(0), 1'b0, 3'd4);
    send(mw(1), 1'b0, 3'd4);
    @(negedge clk);
    chk("fill_busy", 512'(busy_o), 512'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", 512'(busy_o), 512'(0));
    chk("mid_rst_block", sha_block_o, 512'(0));
    chk("mid_rst_pulse", 512'(sha_init_o | sha_next_o), 512'(0));
    chk("mid_rst_s_ready", 512'(s_ready), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pulse", 512'(sha_init_o | sha_next_o), 512'(0));
    @(posedge clk);
    #1;
    b = put(put('0, 0, 32'h61626380), 15, 32'h18);
    exp_blk("abc2", 1'b1, b);
    exp_done("abc2");
    send(32'h61626300, 1'b1, 3'd3);
    wait_done(8);

    repeat (5) @(posedge clk);
    chk("queue_empty", 512'(q.size()), 512'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 core.
- Accepts a message as a stream of 32-bit big-endian words and splits it into 512-bit blocks.
- Appends standard SHA-256 padding (0x80, zero fill, 64-bit bit length) and drives the core's init/next/block interface, honouring core ready.
- Sits between the HMAC control logic (word source) and the core; supports continuation and length offset so the control logic can chain inner/outer HMAC passes.

Parameters:
BYTE_CNT_W, 32, width of the message byte counter; messages of 2^BYTE_CNT_W bytes or more are unsupported and the counter wraps.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_data  in  32  message word; byte 0 in [31:24]
s_valid  in  1  word valid
s_ready  out  1  word accepted when s_valid&&s_ready
s_last  in  1  final word of message
s_nbytes  in  3  valid bytes in last word, 0..4; values >4 treated as 4; ignored when !s_last
cont_i  in  1  sampled on first accepted word: 1 = first block uses next_o (chained hash)
len_offset_i  in  64  bits added to encoded length, sampled on first accepted word
sha_init_o  out  1  one-cycle init pulse to core
sha_next_o  out  1  one-cycle next pulse to core
sha_block_o  out  512  block to core, word 0 in [511:480]
sha_ready_i  in  1  core idle
sha_digest_valid_i  in  1  core digest valid
done_o  out  1  one-cycle pulse: final block digest available
busy_o  out  1  high from first accepted word until done_o

Behaviour:
- Reset: all outputs 0, state IDLE, buffer cleared, byte counter 0, first-block flag set.
- States: IDLE, FILL, ISSUE, LAT, WAITC, EXTRA, DONE.
- IDLE: s_ready=1. The first handshake loads word 0, samples cont_i/len_offset_i, and moves to FILL. It is processed exactly like a FILL word, so a lone last word goes straight to ISSUE.
- FILL: s_ready=1. Word index w (0..15) and byte count advance by 4, or by s_nbytes on the last word.
- Non-last word at w=15: go to ISSUE, final=0.
- Last word: mask unused bytes to 0 and place 0x80 at the first free byte. That byte may be the byte after the last word, i.e. the next word's [31:24]. Zero the rest of the block.
  - If the block holds ≤55 message bytes: set words 14–15 = byte_cnt*8 + len_offset (mod 2^64), final=1.
  - Else final=0 and set pend_extra. If the 0x80 did not fit in this block, set pend_80.
- s_ready=0 in every state except IDLE/FILL.
- ISSUE: wait for sha_ready_i=1, then pulse for one cycle.
  - First block: sha_init_o if cont_i=0, else sha_next_o.
  - Later blocks: sha_next_o.
  - Clear the first-block flag. Go to LAT.
- LAT: one cycle, ignoring sha_ready_i. Go to WAITC.
- WAITC: wait for sha_ready_i=1.
  - If final: go to DONE.
  - Else if pend_extra: go to EXTRA.
  - Else clear the buffer, w=0, go to FILL.
- EXTRA: one cycle. Build block = (pend_80 ? 0x80000000 : 0) in word 0, zeros, length in words 14–15. final=1, go to ISSUE.
- DONE: done_o=1 for one cycle (core digest_valid is high here), busy_o drops. Go to IDLE.
- sha_block_o is held stable from the pulse until WAITC exits.
- sha_init_o and sha_next_o are never high together.
- Empty message: last word with s_nbytes=0 yields block 0x80000000, 0…, length = len_offset.
- Exactly 56..63 bytes → 2 blocks; 64 bytes → 2 blocks, the second starting with 0x80.
- rst mid-operation: immediate return to IDLE with reset values; no pulse is issued in the cycle after rst.

Decomposition:
- Package sha256_pkg: state enum, block/word width constants, PAD_BYTE=8'h80, LEN_W=64.
- Sub-module sha256_pad_word: combinational byte mask/0x80 insertion for one word given s_nbytes.

Test Plan:
- "abc" (1 word, s_nbytes=3), cont_i=0, offset 0 → one sha_init_o.
  - Block word0=0x61626380, word15=0x00000018.
  - After done_o, digest = ba7816bf…f20015ad.
- Empty message (s_nbytes=0) → block 0x80000000, zeros, length 0; digest e3b0c442…7852b855.
- 56-byte message (14 full words) → two blocks.
  - Block 1: data, word14=0x80000000.
  - Block 2: zeros except word15=0x000001C0.
  - Pulses: init, then next.
- 64-byte message → two blocks; block 2 word0=0x80000000, word15=0x00000200.
- "abc" with cont_i=1, len_offset_i=512 → only sha_next_o pulses, word15=0x00000218.
- Hold sha_ready_i=0 for 20 cycles in ISSUE → no pulse, s_ready=0, sha_block_o stable.
  - Pulse occurs the cycle sha_ready_i rises.
  - Assert rst mid-FILL → all outputs 0 the next cycle, and a new "abc" then hashes correctly.
